// File: rtl/multicycle_ctrl.sv
// Multicycle RV32 control FSM: owns every datapath strobe for the shared ALU, PC, RF and memory ports.
// Optional feature macro CTRL_PERF_CNT_EN adds cycle_count / retired_count performance counters.
module multicycle_ctrl (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] inst_encoding,
  output logic        imem_req,
  input  logic        imem_ready,
  output logic        ir_we,
  output logic        dmem_req,
  output logic        dmem_we,
  input  logic        dmem_ready,
  input  logic        alu_zero,
  output logic [3:0]  function_code,
  output logic [2:0]  next_pc_sel,
  output logic        pc_we,
  output logic        rf_we,
  output logic [1:0]  wb_sel,
  output logic        illegal_inst,
  output logic [2:0]  ctrl_state
`ifdef CTRL_PERF_CNT_EN
  ,
  output logic [31:0] cycle_count,
  output logic [31:0] retired_count
`endif
);

  // ALU operation and PC source select codes shared with the datapath
  localparam logic [3:0] ALU_A_PLUS_B      = 4'b0010;
  localparam logic [3:0] ALU_A_MINUS_B     = 4'b0110;
  localparam logic [2:0] PC_FROM_PC_PLUS_4 = 3'b000;
  localparam logic [2:0] PC_PLUS_JAL_IMM   = 3'b001;
  localparam logic [2:0] NEXT_PC_FROM_RF   = 3'b010;
  localparam logic [2:0] PC_PLUS_BRCH_IMM  = 3'b011;

  localparam logic [1:0] WB_ALU  = 2'b00;
  localparam logic [1:0] WB_LOAD = 2'b01;
  localparam logic [1:0] WB_PC4  = 2'b10;

  localparam logic [2:0] ST_BOOT   = 3'd0;
  localparam logic [2:0] ST_FETCH  = 3'd1;
  localparam logic [2:0] ST_DECODE = 3'd2;
  localparam logic [2:0] ST_EXEC   = 3'd3;
  localparam logic [2:0] ST_MEM    = 3'd4;
  localparam logic [2:0] ST_WB     = 3'd5;
  localparam logic [2:0] ST_TRAP   = 3'd6;

  localparam logic [2:0] CLS_ADDI    = 3'd0;
  localparam logic [2:0] CLS_JAL     = 3'd1;
  localparam logic [2:0] CLS_JALR    = 3'd2;
  localparam logic [2:0] CLS_BEQ     = 3'd3;
  localparam logic [2:0] CLS_LW      = 3'd4;
  localparam logic [2:0] CLS_SW      = 3'd5;
  localparam logic [2:0] CLS_ILLEGAL = 3'd6;

  logic [2:0] state_r;
  logic [2:0] next_state_s;
  logic [2:0] class_r;
  logic [2:0] decoded_class_s;
  logic       unused_inst_bits_s;

  function automatic logic [2:0] classify(input logic [6:0] opcode, input logic [2:0] funct3);
    logic [2:0] cls;
    cls = CLS_ILLEGAL;
    case (opcode)
      7'b1101111: cls = CLS_JAL;
      7'b1100111: if (funct3 == 3'b000) cls = CLS_JALR; else cls = CLS_ILLEGAL;
      7'b1100011: if (funct3 == 3'b000) cls = CLS_BEQ;  else cls = CLS_ILLEGAL;
      7'b0010011: if (funct3 == 3'b000) cls = CLS_ADDI; else cls = CLS_ILLEGAL;
      7'b0000011: if (funct3 == 3'b010) cls = CLS_LW;   else cls = CLS_ILLEGAL;
      7'b0100011: if (funct3 == 3'b010) cls = CLS_SW;   else cls = CLS_ILLEGAL;
      default:    cls = CLS_ILLEGAL;
    endcase
    return cls;
  endfunction

  assign decoded_class_s    = classify(inst_encoding[6:0], inst_encoding[14:12]);
  // Operand/immediate fields are consumed by the datapath, not by sequencing
  assign unused_inst_bits_s = ^{inst_encoding[31:15], inst_encoding[11:7]};
  assign ctrl_state         = state_r;

  // State register; the class register captures the decode result only in DECODE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_BOOT;
      class_r <= CLS_ADDI;
    end else begin
      state_r <= next_state_s;
      if (state_r == ST_DECODE) begin
        class_r <= decoded_class_s;
      end else begin
        class_r <= class_r;
      end
    end
  end

  // Next-state and datapath strobe decode
  always_comb begin
    next_state_s  = state_r;
    imem_req      = 1'b0;
    ir_we         = 1'b0;
    dmem_req      = 1'b0;
    dmem_we       = 1'b0;
    pc_we         = 1'b0;
    rf_we         = 1'b0;
    function_code = ALU_A_PLUS_B;
    next_pc_sel   = PC_FROM_PC_PLUS_4;
    wb_sel        = WB_ALU;
    illegal_inst  = 1'b0;
    case (state_r)
      ST_BOOT: next_state_s = ST_FETCH;
      ST_FETCH: begin
        imem_req = 1'b1;
        if (imem_ready) begin
          ir_we        = 1'b1;
          next_state_s = ST_DECODE;
        end else begin
          next_state_s = ST_FETCH;
        end
      end
      ST_DECODE: begin
        if (decoded_class_s == CLS_ILLEGAL) begin
          next_state_s = ST_TRAP;
        end else begin
          next_state_s = ST_EXEC;
        end
      end
      ST_EXEC: begin
        case (class_r)
          CLS_BEQ: begin
            function_code = ALU_A_MINUS_B;
            pc_we         = 1'b1;
            if (alu_zero) begin
              next_pc_sel = PC_PLUS_BRCH_IMM;
            end else begin
              next_pc_sel = PC_FROM_PC_PLUS_4;
            end
            next_state_s = ST_FETCH;
          end
          CLS_ADDI:         next_state_s = ST_WB;
          CLS_LW, CLS_SW:   next_state_s = ST_MEM;
          CLS_JAL, CLS_JALR: next_state_s = ST_WB;
          default:          next_state_s = ST_TRAP;
        endcase
      end
      ST_MEM: begin
        // Request is level-held until the ready cycle
        dmem_req = 1'b1;
        dmem_we  = (class_r == CLS_SW);
        if (dmem_ready) begin
          if (class_r == CLS_SW) begin
            pc_we        = 1'b1;
            next_state_s = ST_FETCH;
          end else begin
            next_state_s = ST_WB;
          end
        end else begin
          next_state_s = ST_MEM;
        end
      end
      ST_WB: begin
        rf_we        = 1'b1;
        pc_we        = 1'b1;
        next_state_s = ST_FETCH;
        case (class_r)
          CLS_LW:  wb_sel = WB_LOAD;
          CLS_JAL: begin
            wb_sel      = WB_PC4;
            next_pc_sel = PC_PLUS_JAL_IMM;
          end
          CLS_JALR: begin
            wb_sel      = WB_PC4;
            next_pc_sel = NEXT_PC_FROM_RF;
          end
          default: wb_sel = WB_ALU;
        endcase
      end
      ST_TRAP: begin
        illegal_inst = 1'b1;
        next_state_s = ST_TRAP;
      end
      default: next_state_s = ST_BOOT;
    endcase
  end

`ifdef CTRL_PERF_CNT_EN
  logic [31:0] cycle_count_r;
  logic [31:0] retired_count_r;

  // Performance counters: active cycles outside BOOT and retired instructions
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cycle_count_r   <= 32'd0;
      retired_count_r <= 32'd0;
    end else begin
      if (state_r != ST_BOOT) begin
        cycle_count_r <= cycle_count_r + 32'd1;
      end else begin
        cycle_count_r <= cycle_count_r;
      end
      if (pc_we) begin
        retired_count_r <= retired_count_r + 32'd1;
      end else begin
        retired_count_r <= retired_count_r;
      end
    end
  end

  assign cycle_count   = cycle_count_r;
  assign retired_count = retired_count_r;
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: directed vector table, trap/reset sequences and
// randomized instructions checked against a per-instruction phase schedule model.
module tb_multicycle_ctrl;

  localparam logic [3:0] A_PLUS_B  = 4'b0010;
  localparam logic [3:0] A_MINUS_B = 4'b0110;
  localparam logic [2:0] NPC_PLUS4 = 3'b000;
  localparam logic [2:0] NPC_JAL   = 3'b001;
  localparam logic [2:0] NPC_RF    = 3'b010;
  localparam logic [2:0] NPC_BRCH  = 3'b011;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] inst_encoding = 32'd0;
  logic        imem_ready = 1'b0, dmem_ready = 1'b0, alu_zero = 1'b0;
  logic        imem_req, ir_we, dmem_req, dmem_we, pc_we, rf_we, illegal_inst;
  logic [3:0]  function_code;
  logic [2:0]  next_pc_sel, ctrl_state;
  logic [1:0]  wb_sel;
`ifdef CTRL_PERF_CNT_EN
  logic [31:0] cycle_count, retired_count;
`endif

  multicycle_ctrl dut (
    .clk(clk), .rst_n(rst_n), .inst_encoding(inst_encoding),
    .imem_req(imem_req), .imem_ready(imem_ready), .ir_we(ir_we),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ready(dmem_ready),
    .alu_zero(alu_zero), .function_code(function_code), .next_pc_sel(next_pc_sel),
    .pc_we(pc_we), .rf_we(rf_we), .wb_sel(wb_sel), .illegal_inst(illegal_inst),
    .ctrl_state(ctrl_state)
`ifdef CTRL_PERF_CNT_EN
    , .cycle_count(cycle_count), .retired_count(retired_count)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] inst;
    logic        imem_ready, dmem_ready, alu_zero;
    logic [2:0]  st;
    logic        imem_req, ir_we, dmem_req, dmem_we, pc_we, rf_we;
    logic [3:0]  fc;
    logic [2:0]  nps;
    logic [1:0]  wb;
    logic        ill;
  } cyc_t;

  typedef struct {
    string       nm;
    logic [31:0] inst;
    int          fw;
    int          dw;
    logic        az;
    int          span;
  } vec_t;

  cyc_t        sched[$];
  vec_t        tbl[8];
  int          n_pass = 0, n_total = 0;
  logic [2:0]  last_state;
  int unsigned model_cycles = 0, model_retired = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
  endtask

  function automatic logic [31:0] act_vec();
    return {13'd0, ctrl_state, imem_req, ir_we, dmem_req, dmem_we, pc_we, rf_we,
            function_code, next_pc_sel, wb_sel, illegal_inst};
  endfunction

  function automatic logic [31:0] exp_vec(input cyc_t e);
    return {13'd0, e.st, e.imem_req, e.ir_we, e.dmem_req, e.dmem_we, e.pc_we, e.rf_we,
            e.fc, e.nps, e.wb, e.ill};
  endfunction

  function automatic string cls_of(input logic [31:0] i);
    logic [6:0] op;
    logic [2:0] f3;
    op = i[6:0];
    f3 = i[14:12];
    if (op == 7'h6F) return "JAL";
    if (op == 7'h67 && f3 == 3'd0) return "JALR";
    if (op == 7'h63 && f3 == 3'd0) return "BEQ";
    if (op == 7'h13 && f3 == 3'd0) return "ADDI";
    if (op == 7'h03 && f3 == 3'd2) return "LW";
    if (op == 7'h23 && f3 == 3'd2) return "SW";
    return "ILL";
  endfunction

  // A quiet cycle in a given state; inputs the controller must ignore are randomized.
  function automatic cyc_t mk(input logic [2:0] st, input logic [31:0] inst);
    cyc_t c;
    c.inst = inst;
    c.imem_ready = 1'($urandom_range(0, 1));
    c.dmem_ready = 1'($urandom_range(0, 1));
    c.alu_zero   = 1'($urandom_range(0, 1));
    c.st = st;
    c.imem_req = 1'b0; c.ir_we = 1'b0; c.dmem_req = 1'b0; c.dmem_we = 1'b0;
    c.pc_we = 1'b0; c.rf_we = 1'b0;
    c.fc = A_PLUS_B; c.nps = NPC_PLUS4; c.wb = 2'b00; c.ill = 1'b0;
    return c;
  endfunction

  // Expected cycle-by-cycle behaviour of one instruction, phase by phase.
  task automatic build(input logic [31:0] inst, input int fw, input int dw, input logic az,
                       input bit add_ret);
    string cl;
    cyc_t  c;
    cl = cls_of(inst);
    sched.delete();
    for (int k = 0; k < fw; k++) begin
      c = mk(3'd1, $urandom); c.imem_req = 1'b1; c.imem_ready = 1'b0; sched.push_back(c);
    end
    c = mk(3'd1, $urandom); c.imem_req = 1'b1; c.imem_ready = 1'b1; c.ir_we = 1'b1;
    sched.push_back(c);
    c = mk(3'd2, inst); sched.push_back(c);
    if (cl == "ILL") begin
      for (int k = 0; k < 3; k++) begin
        c = mk(3'd6, inst); c.ill = 1'b1; sched.push_back(c);
      end
      return;
    end
    c = mk(3'd3, inst);
    if (cl == "BEQ") begin
      c.alu_zero = az; c.fc = A_MINUS_B; c.pc_we = 1'b1;
      c.nps = az ? NPC_BRCH : NPC_PLUS4;
    end
    sched.push_back(c);
    if (cl == "LW" || cl == "SW") begin
      for (int k = 0; k <= dw; k++) begin
        c = mk(3'd4, inst); c.dmem_req = 1'b1; c.dmem_we = (cl == "SW");
        c.dmem_ready = (k == dw);
        c.pc_we = (k == dw) && (cl == "SW");
        sched.push_back(c);
      end
    end
    if (cl != "BEQ" && cl != "SW") begin
      c = mk(3'd5, inst); c.rf_we = 1'b1; c.pc_we = 1'b1;
      if (cl == "LW") c.wb = 2'b01;
      if (cl == "JAL")  begin c.wb = 2'b10; c.nps = NPC_JAL; end
      if (cl == "JALR") begin c.wb = 2'b10; c.nps = NPC_RF;  end
      sched.push_back(c);
    end
    if (add_ret) begin
      c = mk(3'd1, $urandom); c.imem_req = 1'b1; c.imem_ready = 1'b0; sched.push_back(c);
    end
  endtask

  // Entered just after a rising edge; drives one cycle and checks it on the falling edge.
  task automatic cycle(input cyc_t e, input string nm);
    inst_encoding = e.inst;
    imem_ready    = e.imem_ready;
    dmem_ready    = e.dmem_ready;
    alu_zero      = e.alu_zero;
    @(negedge clk);
    last_state = ctrl_state;
    chk(nm, act_vec(), exp_vec(e));
    @(posedge clk);
    #1;
    if (e.st != 3'd0) model_cycles++;
    if (e.pc_we) model_retired++;
  endtask

  // Span = cycles from entering FETCH until the next FETCH is reached, inclusive.
  task automatic run(input string nm, input int lim, output int span);
    bit left, done;
    span = 0; left = 1'b0; done = 1'b0;
    for (int i = 0; i < sched.size() && i < lim; i++) begin
      cycle(sched[i], $sformatf("%s/c%0d", nm, i));
      if (!done) begin
        span++;
        if (last_state != 3'd1) left = 1'b1;
        else if (left) done = 1'b1;
      end
    end
  endtask

  task automatic perf_chk(input string nm);
`ifdef CTRL_PERF_CNT_EN
    chk({nm, "/cycles"},  cycle_count,   model_cycles);
    chk({nm, "/retired"}, retired_count, model_retired);
`else
    n_pass = n_pass + 0;
`endif
  endtask

  task automatic reset_check(input string nm);
    cyc_t boot;
    rst_n = 1'b0;
    #2;
    chk({nm, "/rst"}, act_vec(), {13'd0, 3'd0, 6'b000000, A_PLUS_B, NPC_PLUS4, 2'b00, 1'b0});
    model_cycles = 0;
    model_retired = 0;
    perf_chk({nm, "/rst"});
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    boot = mk(3'd0, $urandom);
    cycle(boot, {nm, "/boot"});
  endtask

  int          span, exp_span, fw, dw, k;
  logic [31:0] r, inst;
  logic        az;
  string       cl;
  logic [31:0] ill_tbl[4];

  initial begin
    tbl[0] = '{"addi",      32'h00500093, 0, 0, 1'b0, 5};
    tbl[1] = '{"beq_taken", 32'h00000063, 0, 0, 1'b1, 4};
    tbl[2] = '{"beq_not",   32'h00000063, 0, 0, 1'b0, 4};
    tbl[3] = '{"lw_wait3",  32'h0000A083, 0, 3, 1'b0, 9};
    tbl[4] = '{"jal",       32'h0000006F, 0, 0, 1'b0, 5};
    tbl[5] = '{"jalr",      32'h00008067, 0, 0, 1'b0, 5};
    tbl[6] = '{"sw",        32'h00002023, 0, 0, 1'b0, 5};
    tbl[7] = '{"addi_fw2",  32'h00500093, 2, 0, 1'b0, 7};
    ill_tbl = '{32'hFFFFFFFF, 32'h00001063, 32'h00001013, 32'h00000033};

    repeat (2) @(posedge clk);
    #1;
    reset_check("init");

    foreach (tbl[t]) begin
      build(tbl[t].inst, tbl[t].fw, tbl[t].dw, tbl[t].az, 1'b1);
      run(tbl[t].nm, 1000, span);
      chk({tbl[t].nm, "/span"}, 32'(span), 32'(tbl[t].span));
      perf_chk(tbl[t].nm);
    end

    for (int n = 0; n < 60; n++) begin
      r  = $urandom;
      k  = int'($urandom_range(0, 5));
      fw = int'($urandom_range(0, 3));
      dw = int'($urandom_range(0, 3));
      az = 1'($urandom_range(0, 1));
      case (k)
        0:       inst = {r[31:7], 7'h6F};
        1:       inst = {r[31:15], 3'b000, r[11:7], 7'h67};
        2:       inst = {r[31:15], 3'b000, r[11:7], 7'h63};
        3:       inst = {r[31:15], 3'b000, r[11:7], 7'h13};
        4:       inst = {r[31:15], 3'b010, r[11:7], 7'h03};
        default: inst = {r[31:15], 3'b010, r[11:7], 7'h23};
      endcase
      cl = cls_of(inst);
      if (cl == "BEQ") exp_span = 4 + fw;
      else if (cl == "LW") exp_span = 6 + fw + dw;
      else if (cl == "SW") exp_span = 5 + fw + dw;
      else exp_span = 5 + fw;
      build(inst, fw, dw, az, 1'b1);
      run($sformatf("rnd%0d_%s", n, cl), 1000, span);
      chk($sformatf("rnd%0d_%s/span", n, cl), 32'(span), 32'(exp_span));
    end
    perf_chk("rnd");

    foreach (ill_tbl[t]) begin
      build(ill_tbl[t], 0, 0, 1'b0, 1'b0);
      run($sformatf("trap%0d", t), 1000, span);
      reset_check($sformatf("trap%0d", t));
    end

    // Reset while a store is stalled in MEM
    build(32'h00402023, 0, 10, 1'b0, 1'b0);
    run("sw_stall", 5, span);
    dmem_ready = 1'b0;
    @(negedge clk);
    chk("sw_stall/req_held", {31'd0, dmem_req}, 32'd1);
    reset_check("sw_stall");

    build(32'h00500093, 1, 0, 1'b0, 1'b1);
    run("addi_after_rst", 1000, span);
    chk("addi_after_rst/span", 32'(span), 32'd6);
    perf_chk("addi_after_rst");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Multicycle control FSM that sequences the single shared ALU, PC register, register file and instruction/data memory ports of the RV32 core. It runs each instruction through BOOT/FETCH/DECODE/EXECUTE/MEM/WRITEBACK, using the codebase's `decode.vh` encodings and select codes. Per cycle it drives `next_pc_sel`, `function_code`, PC/IR/RF write enables and the memory request handshakes. It sits between the instruction register and the datapath muxes and replaces the purely combinational decode path as the owner of all datapath strobes.

## Interface
- No parameters. Encodings and select codes come from `decode.vh`.
- `clk`  in  1  core clock; all state changes on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `inst_encoding`  in  32  instruction register contents, valid from DECODE onward.
- `imem_req`  out  1  instruction fetch request.
- `imem_ready`  in  1  fetch data valid this cycle.
- `ir_we`  out  1  load instruction register.
- `dmem_req`  out  1  data memory request.
- `dmem_we`  out  1  store qualifier, valid with `dmem_req`.
- `dmem_ready`  in  1  data access completes this cycle.
- `alu_zero`  in  1  ALU result == 0.
- `function_code`  out  4  ALU operation (`AplusB`/`AminusB`).
- `next_pc_sel`  out  3  PC source (`PC_FROM_PC_PLUS_4`, `PC_PLUS_JAL_IMM`, `NEXT_PC_FROM_RF`, `PC_PLUS_BRCH_IMM`).
- `pc_we`  out  1  PC register update.
- `rf_we`  out  1  register file write.
- `wb_sel`  out  2  writeback source: 00 ALU, 01 load data, 10 PC+4.
- `illegal_inst`  out  1  sticky trap flag.
- `ctrl_state`  out  3  current state, for debug.

## Operation
- State encoding: BOOT=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, TRAP=6.
- Instruction class register is loaded in DECODE. Classes:
  - JAL: opcode 1101111.
  - JALR: 1100111, funct3 000.
  - BEQ: 1100011, funct3 000.
  - ADDI: 0010011, funct3 000.
  - LW: 0000011, funct3 010.
  - SW: 0100011, funct3 010.
  - Anything else is ILLEGAL.
- All outputs are combinational from state plus the class register. Defaults: every strobe 0, `function_code`=`AplusB`, `next_pc_sel`=`PC_FROM_PC_PLUS_4`, `wb_sel`=00.
- BOOT: all strobes 0; next state FETCH.
- FETCH: `imem_req`=1 until `imem_ready`. In the ready cycle `ir_we`=1 and next state is DECODE; otherwise stay in FETCH.
- DECODE: no strobes. ILLEGAL goes to TRAP; every other class goes to EXEC.
- EXEC, by class:
  - BEQ: `function_code`=`AminusB`, `pc_we`=1. `next_pc_sel`=`PC_PLUS_BRCH_IMM` if `alu_zero`, else `PC_FROM_PC_PLUS_4`. Next state FETCH.
  - ADDI, LW, SW: `AplusB` (address/sum). ADDI goes to WB; LW and SW go to MEM.
  - JAL, JALR: no strobes; next state WB.
- MEM: `dmem_req`=1, `dmem_we`=(class==SW), held until `dmem_ready`.
  - SW, ready cycle: `pc_we`=1 with PC+4; next state FETCH.
  - LW, ready cycle: next state WB.
- WB: `rf_we`=1 and `pc_we`=1; next state FETCH.
  - ADDI: `wb_sel`=00, PC+4.
  - LW: `wb_sel`=01, PC+4.
  - JAL: `wb_sel`=10, `next_pc_sel`=`PC_PLUS_JAL_IMM`.
  - JALR: `wb_sel`=10, `next_pc_sel`=`NEXT_PC_FROM_RF`.
- TRAP: `illegal_inst`=1, all strobes 0, PC frozen. Only reset exits TRAP.

## Timing
- Reset: state=BOOT, class=ILLEGAL-free default (ADDI). All outputs 0 except `function_code`=`AplusB` and `next_pc_sel`=`PC_FROM_PC_PLUS_4`.
- Reset asserted mid-operation forces BOOT immediately (asynchronously) and drops any `imem_req`/`dmem_req` in flight. The memory side must ignore the abandoned request.
- Cycles per instruction with zero-wait memory: BEQ 4, ADDI/JAL/JALR/SW 5, LW 6. Every wait cycle on `imem_ready`/`dmem_ready` adds 1.
- `imem_ready`/`dmem_ready` are ignored outside FETCH/MEM.
- The requests are level-held; a deasserted ready never drops a request.
- `pc_we` is asserted exactly once per retired instruction.
- `rf_we` is never asserted in the same cycle as `dmem_we`.

## Configuration
- `CTRL_PERF_CNT_EN` defined adds two outputs:
  - `cycle_count` [31:0]: increments every cycle outside BOOT.
  - `retired_count` [31:0]: increments on each `pc_we`.
  - Both reset to 0 and wrap modulo 2^32.
- Undefined: neither port nor either counter exists, and behaviour is otherwise identical.

## Test plan
- Reset release, ADDI x1,x0,5 (0x00500093), zero-wait memory -> states 0,1,2,3,5,1. `rf_we` and `pc_we` pulse once in WB with `wb_sel`=00.
- BEQ (0x00000063) with `alu_zero`=1, then with `alu_zero`=0 -> EXEC shows `function_code`=`AminusB` and `pc_we`=1. `next_pc_sel`=`PC_PLUS_BRCH_IMM`, then `PC_FROM_PC_PLUS_4`. 4 cycles each.
- LW (0x0000A083) with `dmem_ready` delayed 3 cycles -> `dmem_req` held 4 cycles with `dmem_we`=0. WB follows with `wb_sel`=01. Total 9 cycles.
- JAL (0x0000006F), then JALR (0x00008067) -> WB `wb_sel`=10, `next_pc_sel`=`PC_PLUS_JAL_IMM`, then `NEXT_PC_FROM_RF`.
- Instruction 0xFFFFFFFF -> TRAP, `illegal_inst`=1, no further `imem_req`. `rst_n` low mid-TRAP returns to BOOT and clears the flag.
- `rst_n` pulsed low during a stalled SW MEM -> `dmem_req` drops immediately and no `pc_we` occurs. With `CTRL_PERF_CNT_EN`, both counters read 0.
